commit_trace_fifo: RTL and testbench

- Hardware commit-trace capture unit downstream of the core's MW (memory/writeback) stage in riscv_top.
- Each retiring instruction is packaged into a trace record: PC, instruction, kind, rd, data, address and a retire sequence number.
- Records are buffered in a FIFO and drained over a valid/ready port toward a trace sink (UART/debug bridge); output order matches the dut_commit.log format.
- Overflow is never back-pressured into the core: records are dropped, counted and made detectable via sequence gaps.

---
 rtl/commit_trace_fifo.sv | 154 +++++++++++++++
 tb/tb_commit_trace_fifo.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
//
// Captures retiring instructions from the MW stage as trace records and
// buffers them for a downstream trace sink (UART / debug bridge).
// Overflow never stalls the core. A record that arrives while the FIFO is
// full is dropped and counted. Because every qualified commit consumes a
// sequence number, a dropped record also shows up as a gap in trace_seq.
//
// Ports
//   clk, rst          core clock; asynchronous active-low reset
//   trace_en          1 = capture commits, 0 = ignore them (sequence holds)
//   commit_*          MW-stage retire info (instr == 0 marks a bubble)
//   trace_valid/ready head-record handshake toward the sink
//   trace_*           head record fields (all zero while empty)
//   level             current occupancy
//   overflow          sticky: a record has been dropped since reset
//   drop_count        saturating count of dropped records
module commit_trace_fifo #(
  parameter int DEPTH  = 16,  // power of two, >= 2
  parameter int DROP_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       trace_en,
  input  logic                       commit_valid,
  input  logic [31:0]                commit_pc,
  input  logic [31:0]                commit_instr,
  input  logic [1:0]                 commit_kind,
  input  logic [4:0]                 commit_rd,
  input  logic [31:0]                commit_data,
  input  logic [31:0]                commit_addr,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [31:0]                trace_seq,
  output logic [31:0]                trace_pc,
  output logic [31:0]                trace_instr,
  output logic [1:0]                 trace_kind,
  output logic [4:0]                 trace_rd,
  output logic [31:0]                trace_data,
  output logic [31:0]                trace_addr,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
  } rec_t;

  rec_t mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg;
  logic [31:0]       seq_reg;
  logic              overflow_reg;
  logic [DROP_W-1:0] drop_count_reg;

  logic qual;
  logic full;
  logic pop;
  logic push;
  logic drop;
  rec_t wr_rec;
  rec_t head_rec;

  assign qual = commit_valid & trace_en & (commit_instr != 32'h0);
  assign full = (level_reg == LVL_FULL);
  assign pop  = trace_valid & trace_ready;
  // A pop in the same cycle frees the slot the new record needs, so a full
  // FIFO still accepts the push.
  assign push = qual & (~full | pop);
  assign drop = qual & full & ~pop;

  always_comb begin
    wr_rec       = '0;
    wr_rec.seq   = seq_reg;
    wr_rec.pc    = commit_pc;
    wr_rec.instr = commit_instr;
    wr_rec.kind  = commit_kind;
    wr_rec.rd    = commit_rd;
    wr_rec.data  = commit_data;
    wr_rec.addr  = commit_addr;
  end

  // Storage carries no reset: contents are only observable through the
  // head, which is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_rec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      seq_reg        <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      // Sequence advances for every qualified commit, stored or dropped.
      if (qual) begin
        seq_reg <= seq_reg + 32'd1;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != {DROP_W{1'b1}}) begin
          drop_count_reg <= drop_count_reg + DROP_W'(1);
        end
      end
    end
  end

  // Valid derives from the registered level, so an asynchronous reset
  // clears it (and the masked head fields) in the same instant.
  assign trace_valid = (level_reg != '0);
  assign head_rec    = trace_valid ? mem[rd_ptr_reg] : '0;

  assign trace_seq   = head_rec.seq;
  assign trace_pc    = head_rec.pc;
  assign trace_instr = head_rec.instr;
  assign trace_kind  = head_rec.kind;
  assign trace_rd    = head_rec.rd;
  assign trace_data  = head_rec.data;
  assign trace_addr  = head_rec.addr;

  assign level      = level_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_commit_trace_fifo.sv
module tb_commit_trace_fifo;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 4;
  localparam int LVL_W  = $clog2(DEPTH + 1);
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              trace_en = 1'b1;
  logic              commit_valid = 1'b0;
  logic [31:0]       commit_pc = '0;
  logic [31:0]       commit_instr = '0;
  logic [1:0]        commit_kind = '0;
  logic [4:0]        commit_rd = '0;
  logic [31:0]       commit_data = '0;
  logic [31:0]       commit_addr = '0;
  logic              trace_valid;
  logic              trace_ready = 1'b0;
  logic [31:0]       trace_seq;
  logic [31:0]       trace_pc;
  logic [31:0]       trace_instr;
  logic [1:0]        trace_kind;
  logic [4:0]        trace_rd;
  logic [31:0]       trace_data;
  logic [31:0]       trace_addr;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  commit_trace_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_instr(commit_instr), .commit_kind(commit_kind),
    .commit_rd(commit_rd), .commit_data(commit_data), .commit_addr(commit_addr),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_seq(trace_seq),
    .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_kind(trace_kind),
    .trace_rd(trace_rd), .trace_data(trace_data), .trace_addr(trace_addr),
    .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] seq_m = '0;
  int          drop_m = 0;
  bit          ovf_m = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    seq_m  = '0;
    drop_m = 0;
    ovf_m  = 1'b0;
  endtask

  // Monitor: on the falling edge the DUT state reflects the last rising
  // edge and the inputs for the next rising edge are already settled.
  rec_t m_rec;
  int   m_sz;
  bit   m_pop;
  bit   m_qual;
  always @(negedge clk) begin
    if (rst) begin
      m_sz = exp_q.size();
      chk("valid", 64'(trace_valid), 64'(m_sz != 0));
      chk("level", 64'(level), 64'(m_sz));
      chk("overflow", 64'(overflow), 64'(ovf_m));
      chk("drop_count", 64'(drop_count), 64'(drop_m));
      if (m_sz != 0) begin
        chk("head_seq", 64'(trace_seq), 64'(exp_q[0].seq));
        chk("head_pc", 64'(trace_pc), 64'(exp_q[0].pc));
        chk("head_instr", 64'(trace_instr), 64'(exp_q[0].instr));
        chk("head_kind", 64'(trace_kind), 64'(exp_q[0].kind));
        chk("head_rd", 64'(trace_rd), 64'(exp_q[0].rd));
        chk("head_data", 64'(trace_data), 64'(exp_q[0].data));
        chk("head_addr", 64'(trace_addr), 64'(exp_q[0].addr));
      end else begin
        chk("empty_fields", {trace_seq, trace_pc} | {trace_instr, trace_data}
            | {trace_addr, 25'd0, trace_kind, trace_rd}, 64'd0);
      end
      m_pop = (m_sz != 0) && trace_ready;
      if (m_pop) begin
        $display("pop  seq=%0d pc=%08h instr=%08h kind=%0d rd=%0d data=%08h addr=%08h",
                 exp_q[0].seq, exp_q[0].pc, exp_q[0].instr, exp_q[0].kind,
                 exp_q[0].rd, exp_q[0].data, exp_q[0].addr);
        void'(exp_q.pop_front());
      end
      m_qual = commit_valid && trace_en && (commit_instr != 32'h0);
      if (m_qual) begin
        m_rec.seq   = seq_m;
        m_rec.pc    = commit_pc;
        m_rec.instr = commit_instr;
        m_rec.kind  = commit_kind;
        m_rec.rd    = commit_rd;
        m_rec.data  = commit_data;
        m_rec.addr  = commit_addr;
        seq_m = seq_m + 32'd1;
        if (m_sz == DEPTH && !m_pop) begin
          if (drop_m < DROP_MAX) drop_m++;
          ovf_m = 1'b1;
          $display("drop seq=%0d", m_rec.seq);
        end else begin
          exp_q.push_back(m_rec);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [1:0] kind, input logic [4:0] rd,
                        input logic [31:0] data, input logic [31:0] addr);
    commit_pc    = pc;
    commit_instr = instr;
    commit_kind  = kind;
    commit_rd    = rd;
    commit_data  = data;
    commit_addr  = addr;
    commit_valid = 1'b1;
    cyc();
    commit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    commit_valid = 1'b0;
    repeat (n) cyc();
  endtask

  // Called just after a rising edge; reset is pulsed between edges.
  task automatic do_reset();
    commit_valid = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_seq_field", 64'(trace_seq), 64'd0);
    #1;
    rst = 1'b1;
  endtask

  task automatic store_commit(input int i);
    commit(32'h1000 + 32'(4 * i), 32'h0020a023, 2'd3, 5'(i), $urandom, 32'h100 + 32'(4 * i));
  endtask

  logic [DROP_W-1:0] drop_snap;

  initial begin
    // Reset state
    cyc();
    chk("init_valid", 64'(trace_valid), 64'd0);
    chk("init_level", 64'(level), 64'd0);
    chk("init_drop", 64'(drop_count), 64'd0);
    rst = 1'b1;
    cyc();

    // Basic single commit with ready held high
    trace_ready = 1'b1;
    commit(32'h0, 32'h00500093, 2'd1, 5'd1, 32'd5, 32'h0);
    chk("basic_valid", 64'(trace_valid), 64'd1);
    chk("basic_seq", 64'(trace_seq), 64'd0);
    chk("basic_pc", 64'(trace_pc), 64'd0);
    chk("basic_rd", 64'(trace_rd), 64'd1);
    chk("basic_data", 64'(trace_data), 64'd5);
    cyc();
    chk("basic_drained_valid", 64'(trace_valid), 64'd0);
    chk("basic_drained_level", 64'(level), 64'd0);

    // Bubble and enable filtering
    do_reset();
    commit(32'h4, 32'h0, 2'd1, 5'd2, 32'd7, 32'h0);
    trace_en = 1'b0;
    commit(32'h8, 32'h00100113, 2'd1, 5'd2, 32'd1, 32'h0);
    trace_en = 1'b1;
    idle(2);
    chk("filter_valid", 64'(trace_valid), 64'd0);
    chk("filter_level", 64'(level), 64'd0);
    commit(32'hC, 32'h00200193, 2'd1, 5'd3, 32'd2, 32'h0);
    chk("filter_seq", 64'(trace_seq), 64'd0);
    idle(2);

    // Fill under back-pressure, then one overflow
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) store_commit(i);
    chk("fill_level", 64'(level), 64'(DEPTH));
    chk("fill_head_addr", 64'(trace_addr), 64'h100);
    idle(3);
    chk("fill_stable_addr", 64'(trace_addr), 64'h100);
    store_commit(DEPTH);
    chk("ovf_drop", 64'(drop_count), 64'd1);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_level", 64'(level), 64'(DEPTH));
    trace_ready = 1'b1;
    idle(DEPTH + 1);
    commit(32'h2000, 32'h00300213, 2'd1, 5'd4, 32'd3, 32'h0);
    chk("after_drop_seq", 64'(trace_seq), 64'd17);
    idle(2);

    // Full with simultaneous pop and push
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) store_commit(i);
    drop_snap = drop_count;
    trace_ready = 1'b1;
    commit(32'h3000, 32'h00400293, 2'd2, 5'd5, 32'hDEAD, 32'h3000);
    trace_ready = 1'b0;
    idle(2);
    chk("pp_level", 64'(level), 64'(DEPTH));
    chk("pp_drop", 64'(drop_count), 64'(drop_snap));
    trace_ready = 1'b1;
    idle(DEPTH + 2);

    // Drop counter saturation
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + DROP_MAX + 5; i++) store_commit(i);
    chk("sat_drop", 64'(drop_count), 64'(DROP_MAX));
    chk("sat_ovf", 64'(overflow), 64'd1);
    trace_ready = 1'b1;
    idle(DEPTH + 2);

    // Pointer wrap with ready toggling
    for (int i = 0; i < 40; i++) begin
      trace_ready = i[0];
      commit($urandom, $urandom | 32'h1, 2'($urandom), 5'($urandom), $urandom, $urandom);
    end
    trace_ready = 1'b1;
    idle(DEPTH + 2);

    // Async reset mid-stream
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) store_commit(i);
    chk("mid_level", 64'(level), 64'd5);
    do_reset();
    trace_ready = 1'b1;
    commit(32'h40, 32'h00600313, 2'd1, 5'd6, 32'd6, 32'h0);
    chk("post_rst_seq", 64'(trace_seq), 64'd0);
    chk("post_rst_valid", 64'(trace_valid), 64'd1);
    idle(2);

    // Randomised traffic with bursty back-pressure
    for (int i = 0; i < 600; i++) begin
      trace_en     = ($urandom_range(0, 9) != 0);
      trace_ready  = ((i / 25) % 2 == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      commit_pc    = $urandom;
      commit_instr = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom | 32'h1);
      commit_kind  = 2'($urandom);
      commit_rd    = 5'($urandom);
      commit_data  = $urandom;
      commit_addr  = $urandom;
      commit_valid = ($urandom_range(0, 9) < 7);
      cyc();
    end
    trace_en = 1'b1;
    trace_ready = 1'b1;
    idle(DEPTH + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
